// File: rtl/spi_pkg.sv
// Shared SPIBR field layout, reset value and write mask for the SPI register file.
package spi_pkg;

  localparam int unsigned SPR_LSB     = 0;
  localparam int unsigned SPPR_LSB    = 4;
  localparam logic [7:0]  SPIBR_RESET = 8'h00;
  localparam logic [7:0]  SPIBR_WMASK = 8'h77;

endpackage

// File: rtl/spi_baud_gen.sv
// Baud tick generator: free-running 0..divisor-1 counter with a registered one-cycle tick.
module spi_baud_gen #(
  parameter int unsigned DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] divisor,
  output logic             baud_tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  // A rate change realigns the phase: counter back to 0 and the tick suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      baud_tick <= 1'b0;
    end else if (restart) begin
      cnt       <= '0;
      baud_tick <= 1'b0;
    end else if (cnt == divisor - ONE) begin
      cnt       <= '0;
      baud_tick <= 1'b1;
    end else begin
      cnt       <= cnt + ONE;
      baud_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_baud_rate_reg.sv
// SPIBR register: captures the baud-rate byte every clock, decodes SPR/SPPR and drives the baud tick.
module spi_baud_rate_reg
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       SPIBR_in,
  output logic             SPR0,
  output logic             SPR1,
  output logic             SPR2,
  output logic [2:0]       SPPR,
  output logic [7:0]       SPIBR_out,
  output logic [DIV_W-1:0] divisor,
  output logic             baud_tick
);

  logic [7:0]       spibr_q;
  logic [7:0]       spibr_d;
  logic [2:0]       spr;
  logic [DIV_W-1:0] sppr_plus1;
  logic             restart;

  assign spibr_d = SPIBR_in & SPIBR_WMASK;
  // Compare the incoming byte against the held one so the counter restarts on the same edge the new rate lands.
  assign restart = (spibr_d != spibr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) spibr_q <= SPIBR_RESET;
    else      spibr_q <= spibr_d;
  end

  assign spr       = spibr_q[SPR_LSB +: 3];
  assign SPR0      = spr[0];
  assign SPR1      = spr[1];
  assign SPR2      = spr[2];
  assign SPPR      = spibr_q[SPPR_LSB +: 3];
  assign SPIBR_out = spibr_q;

  assign sppr_plus1 = DIV_W'({1'b0, SPPR}) + DIV_W'(1);
  assign divisor    = sppr_plus1 << ({1'b0, spr} + 4'd1);

  spi_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk       (clk),
    .rst_n     (rst),
    .restart   (restart),
    .divisor   (divisor),
    .baud_tick (baud_tick)
  );

endmodule

// File: tb/tb_spi_baud_rate_reg.sv
// Self-checking bench for spi_baud_rate_reg: vector table, corner sequences and random run vs a reference model.
module tb_spi_baud_rate_reg;

  localparam int unsigned DIV_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       SPIBR_in = 8'h00;
  logic             SPR0, SPR1, SPR2;
  logic [2:0]       SPPR;
  logic [7:0]       SPIBR_out;
  logic [DIV_W-1:0] divisor;
  logic             baud_tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: register value, edges since reset, edge index of last restart.
  logic [7:0] m_reg;
  int         m_n;
  int         m_start;

  spi_baud_rate_reg #(.DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .SPIBR_in  (SPIBR_in),
    .SPR0      (SPR0),
    .SPR1      (SPR1),
    .SPR2      (SPR2),
    .SPPR      (SPPR),
    .SPIBR_out (SPIBR_out),
    .divisor   (divisor),
    .baud_tick (baud_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_out;
    int         exp_div;
    logic [2:0] exp_spr;
    logic [2:0] exp_sppr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int model_div(input logic [7:0] r);
    int sppr_v = int'(r[6:4]);
    int spr_v  = int'(r[2:0]);
    return (sppr_v + 1) * (2 ** (spr_v + 1));
  endfunction

  function automatic int model_tick();
    int since = m_n - m_start;
    return (since > 0 && (since % model_div(m_reg)) == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_reg   = 8'h00;
    m_n     = 0;
    m_start = 0;
  endtask

  task automatic chk_model(input string name);
    chk({name, ".spr"},  int'({SPR2, SPR1, SPR0}), int'(m_reg[2:0]));
    chk({name, ".sppr"}, int'(SPPR), int'(m_reg[6:4]));
    chk({name, ".out"},  int'(SPIBR_out), int'(m_reg));
    chk({name, ".div"},  int'(divisor), model_div(m_reg));
    chk({name, ".tick"}, int'(baud_tick), model_tick());
  endtask

  // One rising edge, then the model advances with the byte that was presented.
  task automatic step();
    logic [7:0] w;
    w = SPIBR_in & 8'h77;
    @(posedge clk);
    #1;
    m_n++;
    if (w != m_reg) begin
      m_reg   = w;
      m_start = m_n;
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".spr"},  int'({SPR2, SPR1, SPR0}), 0);
    chk({name, ".sppr"}, int'(SPPR), 0);
    chk({name, ".out"},  int'(SPIBR_out), 0);
    chk({name, ".div"},  int'(divisor), 2);
    chk({name, ".tick"}, int'(baud_tick), 0);
  endtask

  // Edges until the next tick, bounded; returns -1 on timeout.
  task automatic edges_to_tick(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (baud_tick) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int e;

    vecs[0] = '{8'h1E, 8'h16,  256, 3'b110, 3'd1};
    vecs[1] = '{8'h3A, 8'h32,   32, 3'b010, 3'd3};
    vecs[2] = '{8'hFF, 8'h77, 2048, 3'b111, 3'd7};
    vecs[3] = '{8'h88, 8'h00,    2, 3'b000, 3'd0};
    vecs[4] = '{8'h5C, 8'h54,  192, 3'b100, 3'd5};
    vecs[5] = '{8'h07, 8'h07,  256, 3'b111, 3'd0};
    vecs[6] = '{8'h70, 8'h70,   16, 3'b000, 3'd7};

    // Asynchronous reset with no clock edge, then reset holding over an edge.
    SPIBR_in = 8'hA5;
    #1 rst = 1'b0;
    #2;
    chk_reset_vals("reset_async");
    SPIBR_in = 8'hFF;
    @(posedge clk); #1;
    chk_reset_vals("reset_wins");
    model_reset();

    @(negedge clk);
    SPIBR_in = 8'h00;
    rst = 1'b1;

    // Minimum divisor: tick alternates 0,1,0,1.
    for (int i = 0; i < 6; i++) begin
      step();
      chk("tick_div2", int'(baud_tick), (i % 2 == 1) ? 1 : 0);
      chk_model("div2");
    end

    // Table of load vectors.
    for (int i = 0; i < 7; i++) begin
      SPIBR_in = vecs[i].din;
      if (i == 1) begin
        #2;
        chk("hold_before_edge", int'(SPIBR_out), 8'h16);
      end
      step();
      chk($sformatf("vec%0d.out", i),  int'(SPIBR_out), int'(vecs[i].exp_out));
      chk($sformatf("vec%0d.div", i),  int'(divisor), vecs[i].exp_div);
      chk($sformatf("vec%0d.spr", i),  int'({SPR2, SPR1, SPR0}), int'(vecs[i].exp_spr));
      chk($sformatf("vec%0d.sppr", i), int'(SPPR), int'(vecs[i].exp_sppr));
      chk($sformatf("vec%0d.tick", i), int'(baud_tick), 0);
    end

    // Longest period: 2048 from the restart, then 2048 between ticks.
    SPIBR_in = 8'h77;
    step();
    edges_to_tick(2100, e);
    chk("div2048_first", e, 2048);
    edges_to_tick(2100, e);
    chk("div2048_period", e, 2048);

    // Rate change mid-count: divisor 8 -> 4 with the counter at 5.
    SPIBR_in = 8'h02;
    step();
    chk("rate_div8", int'(divisor), 8);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rate_no_tick", int'(baud_tick), 0);
    end
    SPIBR_in = 8'h10;
    step();
    chk("rate_div4", int'(divisor), 4);
    chk("rate_restart_tick", int'(baud_tick), 0);
    edges_to_tick(20, e);
    chk("rate_first_tick", e, 4);

    // Same value rewritten with ignored bits flipped must not disturb the period.
    SPIBR_in = 8'h98;
    edges_to_tick(20, e);
    chk("rewrite_same", e, 4);

    // Asynchronous reset mid-count, first tick two edges after release.
    SPIBR_in = 8'h33;
    step();
    step();
    #3 rst = 1'b0;
    #1;
    chk_reset_vals("reset_midcount");
    model_reset();
    SPIBR_in = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    edges_to_tick(20, e);
    chk("reset_first_tick", e, 2);

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) SPIBR_in = 8'($urandom) & 8'hB3;
        else                           SPIBR_in = 8'($urandom);
      end else if ($urandom_range(0, 31) == 0) begin
        SPIBR_in = SPIBR_in ^ 8'h88;
      end
      step();
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
